wr_bus_serializer: RTL and testbench

//  Write-path feeder upstream of top_asyncFIFO_wr. Accepts 64-bit result words from the core under valid/ready.

---
 rtl/wr_bus_pkg.sv | 25 ++
 rtl/gearbox_64to32.sv | 68 ++++++
 rtl/wr_bus_serializer.sv | 140 ++++++++++++++
 tb/tb_wr_bus_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_bus_pkg.sv
// Shared definitions for the write-path serializer feeding top_asyncFIFO_wr.
// Contents:
//   state_e              controller states (IDLE, CFG, WAIT_CFG, STREAM, DONE)
//   WHICH_WRITE_*        one-hot destination codes carried by the config pulse
//   SPI_WIDTH_DEFAULT    default bus beat width (input word is twice this)
//   LEN_W_DEFAULT        default width of the burst length and word counters
package wr_bus_pkg;

    localparam int SPI_WIDTH_DEFAULT = 32;
    localparam int LEN_W_DEFAULT     = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG      = 3'd1,
        ST_WAIT_CFG = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [3:0] WHICH_WRITE_0 = 4'b0001;
    localparam logic [3:0] WHICH_WRITE_1 = 4'b0010;
    localparam logic [3:0] WHICH_WRITE_2 = 4'b0100;
    localparam logic [3:0] WHICH_WRITE_3 = 4'b1000;

endpackage

// File: rtl/gearbox_64to32.sv
// 2:1 width gearbox: holds one 2*SPI_WIDTH word and emits it as two beats,
// low half first.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   stream_i       controller is streaming; words may be loaded
//   room_i         burst still has words left to accept
//   in_valid_i     upstream word valid
//   in_data_i      upstream word
//   in_ready_o     word is taken when in_valid_i && in_ready_o
//   wr_ready_i     downstream can take a beat this cycle
//   wr_req_o       beat issued this cycle
//   wr_data_o      beat data, zero while the hold register is empty
//   hi_beat_o      the beat issued this cycle is a high half (word finished)
module gearbox_64to32 #(
    parameter int SPI_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stream_i,
    input  logic                   room_i,
    input  logic                   in_valid_i,
    input  logic [2*SPI_WIDTH-1:0] in_data_i,
    output logic                   in_ready_o,
    input  logic                   wr_ready_i,
    output logic                   wr_req_o,
    output logic [SPI_WIDTH-1:0]   wr_data_o,
    output logic                   hi_beat_o
);

    logic [2*SPI_WIDTH-1:0] hold_q;
    logic                   hold_valid_q;
    logic                   half_q;
    logic                   beat_s;
    logic                   load_s;

    assign beat_s    = hold_valid_q && wr_ready_i;
    assign wr_req_o  = beat_s;
    assign hi_beat_o = beat_s && half_q;

    // A new word may land in the same cycle the high half leaves, so a
    // steady stream needs no bubble between words.
    assign in_ready_o = stream_i && room_i && (!hold_valid_q || (half_q && wr_ready_i));
    assign load_s     = in_valid_i && in_ready_o;

    assign wr_data_o = hold_valid_q ? (half_q ? hold_q[2*SPI_WIDTH-1:SPI_WIDTH]
                                              : hold_q[SPI_WIDTH-1:0])
                                    : {SPI_WIDTH{1'b0}};

    // Hold register and half-select; both freeze while wr_ready_i is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= {(2*SPI_WIDTH){1'b0}};
            hold_valid_q <= 1'b0;
            half_q       <= 1'b0;
        end else if (load_s) begin
            hold_q       <= in_data_i;
            hold_valid_q <= 1'b1;
            half_q       <= 1'b0;
        end else if (beat_s) begin
            hold_valid_q <= !half_q;
            half_q       <= !half_q;
        end else begin
            hold_valid_q <= hold_valid_q;
            half_q       <= half_q;
        end
    end

endmodule

// File: rtl/wr_bus_serializer.sv
// Write-path feeder for top_asyncFIFO_wr. On cfg_start it issues one config
// pulse carrying the destination code, waits for config_ready, then streams
// cfg_len words of 2*SPI_WIDTH bits as 2*cfg_len SPI_WIDTH-bit beats (low
// half first), pulses done and returns to idle.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_start/cfg_which/cfg_len burst request, sampled only in idle
//   in_valid/in_data/in_ready   upstream word handshake
//   config_paulse/config_data   one-cycle config request and destination code
//   config_ready                FIFO config acknowledge (level)
//   wr_ready/wr_req/wr_data     downstream beat interface
//   busy                        high in every state except idle
//   done                        one-cycle pulse after the last beat
module wr_bus_serializer
    import wr_bus_pkg::*;
#(
    parameter int SPI_WIDTH = SPI_WIDTH_DEFAULT,
    parameter int LEN_W     = LEN_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic [3:0]             cfg_which,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   in_valid,
    input  logic [2*SPI_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   config_paulse,
    output logic [3:0]             config_data,
    input  logic                   config_ready,
    input  logic                   wr_ready,
    output logic                   wr_req,
    output logic [SPI_WIDTH-1:0]   wr_data,
    output logic                   busy,
    output logic                   done
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [3:0]       which_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] accepted_q;
    logic [LEN_W-1:0] sent_q;
    logic             paulse_q;
    logic             busy_q;
    logic             done_q;

    logic             stream_s;
    logic             room_s;
    logic             load_s;
    logic             hi_beat_s;

    assign stream_s = (state_q == ST_STREAM);
    // Equality is enough: the counter never passes len within a burst.
    assign room_s   = (accepted_q != len_q);
    assign load_s   = in_valid && in_ready;

    gearbox_64to32 #(
        .SPI_WIDTH (SPI_WIDTH)
    ) u_gearbox (
        .clk        (clk),
        .rst_n      (rst_n),
        .stream_i   (stream_s),
        .room_i     (room_s),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .wr_ready_i (wr_ready),
        .wr_req_o   (wr_req),
        .wr_data_o  (wr_data),
        .hi_beat_o  (hi_beat_s)
    );

    // Controller FSM with burst counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            which_q    <= 4'b0000;
            len_q      <= LEN_ZERO;
            accepted_q <= LEN_ZERO;
            sent_q     <= LEN_ZERO;
            paulse_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            paulse_q <= 1'b0;
            done_q   <= 1'b0;
            if (load_s) begin
                accepted_q <= accepted_q + LEN_ONE;
            end
            if (hi_beat_s) begin
                sent_q <= sent_q + LEN_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    // A zero-length request is dropped without a config pulse.
                    if (cfg_start && (cfg_len != LEN_ZERO)) begin
                        state_q    <= ST_CFG;
                        which_q    <= cfg_which;
                        len_q      <= cfg_len;
                        accepted_q <= LEN_ZERO;
                        sent_q     <= LEN_ZERO;
                        paulse_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CFG: begin
                    state_q <= ST_WAIT_CFG;
                end
                ST_WAIT_CFG: begin
                    if (config_ready) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (hi_beat_s && (sent_q == (len_q - LEN_ONE))) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign config_paulse = paulse_q;
    assign config_data   = which_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_wr_bus_serializer.sv
module tb_wr_bus_serializer;
    import wr_bus_pkg::*;

    localparam int SW = SPI_WIDTH_DEFAULT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [3:0]    cfg_which = 4'b0000;
    logic [15:0]   cfg_len = 16'd0;
    logic          in_valid = 1'b0;
    logic [2*SW-1:0] in_data = 64'd0;
    logic          in_ready;
    logic          config_paulse;
    logic [3:0]    config_data;
    logic          config_ready = 1'b0;
    logic          wr_ready = 1'b0;
    logic          wr_req;
    logic [SW-1:0] wr_data;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    logic [63:0] words_g[$];

    wr_bus_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_which     (cfg_which),
        .cfg_len       (cfg_len),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .config_paulse (config_paulse),
        .config_data   (config_data),
        .config_ready  (config_ready),
        .wr_ready      (wr_ready),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // One burst, cycle by cycle, against a beat-queue model of the spec.
    // wr_mode: 0 always ready, 1 toggling, 2 random. valid_mode: 0 held, 1 random.
    task automatic run_burst(input logic [3:0] which, input int len, input int cfg_delay,
                             input int wr_mode, input int valid_mode, input int abort_beats,
                             input bit poke, output int beats_o, output int span_o);
        logic [31:0] q[$];
        logic [63:0] w;
        logic [31:0] exp_data;
        int cyc, pulse_cyc, ready_cyc, acc, beats, first_beat, last_beat, done_cyc, widx;
        bit fin, exp_ir, exp_req, exp_busy;
        pulse_cyc = -1; ready_cyc = -1; acc = 0; beats = 0; first_beat = -1;
        last_beat = -1; done_cyc = -1; widx = 0; fin = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_which = which; cfg_len = 16'(len);
        in_valid = 1'b0; wr_ready = 1'b0; config_ready = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 600) begin
            config_ready = (pulse_cyc >= 0) && (cyc >= pulse_cyc + cfg_delay);
            case (wr_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = ((cyc % 2) == 1);
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            w = (widx < words_g.size()) ? words_g[widx] : {$urandom, $urandom};
            in_data = w;
            if (poke && ready_cyc >= 0 && cyc == ready_cyc + 2) begin
                cfg_start = 1'b1; cfg_len = 16'(len + 3); cfg_which = ~which;
            end else begin
                cfg_start = 1'b0;
            end
            #1;
            exp_ir   = (ready_cyc >= 0) && (acc < len) && (q.size() == 0 || (q.size() == 1 && wr_ready));
            exp_req  = (q.size() > 0) && wr_ready;
            exp_data = (q.size() > 0) ? q[0] : 32'h0;
            exp_busy = (done_cyc < 0) || (cyc <= done_cyc);
            checks++;
            if (config_paulse !== (cyc == 1)) begin
                errors++; $display("FAIL config_paulse cyc=%0d: got %b want %b", cyc, config_paulse, (cyc == 1));
            end
            if (exp_busy) begin
                checks++;
                if (config_data !== which) begin
                    errors++; $display("FAIL config_data cyc=%0d: got %h want %h", cyc, config_data, which);
                end
            end
            checks++;
            if (in_ready !== exp_ir) begin
                errors++; $display("FAIL in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ir);
            end
            checks++;
            if (wr_req !== exp_req) begin
                errors++; $display("FAIL wr_req cyc=%0d: got %b want %b", cyc, wr_req, exp_req);
            end
            checks++;
            if (wr_data !== exp_data) begin
                errors++; $display("FAIL wr_data cyc=%0d: got %h want %h", cyc, wr_data, exp_data);
            end
            checks++;
            if (done !== (done_cyc == cyc)) begin
                errors++; $display("FAIL done cyc=%0d: got %b want %b", cyc, done, (done_cyc == cyc));
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++; $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, exp_busy);
            end
            // model update
            if (config_paulse && pulse_cyc < 0) pulse_cyc = cyc;
            if (config_ready && pulse_cyc >= 0 && cyc > pulse_cyc && ready_cyc < 0) ready_cyc = cyc;
            if (wr_req) begin
                if (q.size() > 0) void'(q.pop_front());
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                if (beats == 2 * len) done_cyc = cyc + 1;
            end
            if (in_valid && in_ready) begin
                q.push_back(w[31:0]);
                q.push_back(w[63:32]);
                acc++;
                widx++;
            end
            if (abort_beats != 0 && beats == abort_beats) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({in_ready, config_paulse, wr_req, busy, done} !== 5'b0 ||
                    config_data !== 4'h0 || wr_data !== 32'h0) begin
                    errors++;
                    $display("FAIL abort_outputs: got ir=%b cp=%b req=%b busy=%b done=%b cd=%h wd=%h want all 0",
                             in_ready, config_paulse, wr_req, busy, done, config_data, wr_data);
                end
                fin = 1'b1;
            end else if (done_cyc >= 0 && cyc == done_cyc + 2) begin
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL burst_timeout: got %0d beats want %0d", beats, 2 * len);
        end
        cfg_start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0; config_ready = 1'b0;
        beats_o = beats;
        span_o  = last_beat - first_beat;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({in_ready, config_paulse, wr_req, busy, done} !== 5'b0 ||
            config_data !== 4'h0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ir=%b cp=%b req=%b busy=%b done=%b cd=%h wd=%h want all 0",
                     in_ready, config_paulse, wr_req, busy, done, config_data, wr_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int b, s;
        words_g = '{64'h11112222_33334444, 64'h55556666_77778888};
        run_burst(4'b0011, 2, 3, 0, 0, 0, 1'b0, b, s);
        checks++;
        if (b !== 4) begin errors++; $display("FAIL basic_beats: got %0d want 4", b); end
        words_g.delete();
    endtask

    task automatic test_stall();
        int b, s;
        words_g = '{64'h11112222_33334444, 64'h55556666_77778888};
        run_burst(4'b0011, 2, 3, 1, 0, 0, 1'b0, b, s);
        checks++;
        if (b !== 4) begin errors++; $display("FAIL stall_beats: got %0d want 4", b); end
        words_g.delete();
    endtask

    task automatic test_back_to_back();
        int b, s;
        run_burst(WHICH_WRITE_2, 4, 2, 0, 0, 0, 1'b0, b, s);
        checks++;
        if (b !== 8 || s !== 7) begin
            errors++; $display("FAIL back_to_back: got beats=%0d span=%0d want beats=8 span=7", b, s);
        end
    endtask

    task automatic test_ignore();
        int b, s;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_len = 16'd0; cfg_which = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cfg_start = 1'b0;
            #1;
            checks++;
            if (config_paulse !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL len0_ignored: got cp=%b busy=%b want 0 0", config_paulse, busy);
            end
        end
        // Restart request mid-stream must not change the captured length or code.
        run_burst(WHICH_WRITE_1, 3, 1, 0, 1, 0, 1'b1, b, s);
        checks++;
        if (b !== 6) begin errors++; $display("FAIL poke_beats: got %0d want 6", b); end
    endtask

    task automatic test_reset_mid();
        int b, s;
        run_burst(WHICH_WRITE_3, 4, 2, 0, 0, 3, 1'b0, b, s);
        checks++;
        if (b !== 3) begin errors++; $display("FAIL abort_beats: got %0d want 3", b); end
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(WHICH_WRITE_0, 2, 2, 0, 0, 0, 1'b0, b, s);
        checks++;
        if (b !== 4) begin errors++; $display("FAIL after_abort_beats: got %0d want 4", b); end
    endtask

    task automatic test_wait_cfg();
        int b, s;
        run_burst(4'b1010, 2, 51, 0, 0, 0, 1'b0, b, s);
        checks++;
        if (b !== 4) begin errors++; $display("FAIL wait_cfg_beats: got %0d want 4", b); end
    endtask

    task automatic test_random();
        int b, s, len;
        logic [3:0] codes [4];
        codes = '{WHICH_WRITE_0, WHICH_WRITE_1, WHICH_WRITE_2, WHICH_WRITE_3};
        for (int i = 0; i < 12; i++) begin
            len = $urandom_range(1, 6);
            run_burst(codes[$urandom_range(0, 3)], len, $urandom_range(1, 4), 2, 1, 0, 1'b0, b, s);
            checks++;
            if (b !== 2 * len) begin
                errors++; $display("FAIL random_beats burst=%0d: got %0d want %0d", i, b, 2 * len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_wait_cfg();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
